// File: rtl/nbit_cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// FSM state encoding, one-hot result flags and an index-width helper.
package nbit_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // Result flags packed as {Gth, E, Lth}
  localparam logic [2:0] FLAG_NONE = 3'b000;
  localparam logic [2:0] FLAG_GT   = 3'b100;
  localparam logic [2:0] FLAG_EQ   = 3'b010;
  localparam logic [2:0] FLAG_LT   = 3'b001;

  // Never returns 0 so a single-chunk build still gets a 1-bit index
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of two CHUNK-bit slices, built as an
// MSB-first cascade of single-bit comparator cells.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // eq_above[i] is high when every bit above position i matches
  logic [CHUNK:0]   eq_above;
  logic [CHUNK-1:0] gt_bit;
  logic [CHUNK-1:0] lt_bit;

  assign eq_above[CHUNK] = 1'b1;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
    assign eq_above[gi] = eq_above[gi+1] & ~(a[gi] ^ b[gi]);
    assign gt_bit[gi]   = eq_above[gi+1] & a[gi] & ~b[gi];
    assign lt_bit[gi]   = eq_above[gi+1] & ~a[gi] & b[gi];
  end

  assign gt = |gt_bit;
  assign lt = |lt_bit;
  assign eq = eq_above[0];

endmodule

// File: rtl/nbit_seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first
// differing chunk. Define NBIT_CMP_SIGNED_EN to add two's-complement compare.
module nbit_seq_comparator
  import nbit_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef NBIT_CMP_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Gth,
  output logic             E,
  output logic             Lth
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = clog2(NCHUNK);

`ifdef NBIT_CMP_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
`endif

  cmp_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic [2:0]       flags_reg, flags_next;

  logic chunk_gt, chunk_eq, chunk_lt;

  chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_chunk_cmp (
    .a  (a_reg[WIDTH-1 -: CHUNK]),
    .b  (b_reg[WIDTH-1 -: CHUNK]),
    .gt (chunk_gt),
    .eq (chunk_eq),
    .lt (chunk_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      flags_reg <= FLAG_NONE;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      idx_reg   <= idx_next;
      flags_reg <= flags_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    idx_next   = idx_reg;
    flags_next = flags_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next = A;
          b_next = B;
`ifdef NBIT_CMP_SIGNED_EN
          if (is_signed) begin
            a_next = A ^ MSB_MASK;
            b_next = B ^ MSB_MASK;
          end
`endif
          idx_next   = IDXW'(NCHUNK - 1);
          state_next = RUN;
        end
      end
      RUN: begin
        if (chunk_gt) begin
          flags_next = FLAG_GT;
          state_next = DONE;
        end else if (chunk_lt) begin
          flags_next = FLAG_LT;
          state_next = DONE;
        end else if (idx_reg == '0) begin
          flags_next = FLAG_EQ;
          state_next = DONE;
        end else begin
          a_next   = a_reg << CHUNK;
          b_next   = b_reg << CHUNK;
          idx_next = idx_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Single-bit-per-chunk sanity: chunk_eq is implied by !gt && !lt
  logic unused_eq;
  assign unused_eq = chunk_eq;

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign Gth  = flags_reg[2];
  assign E    = flags_reg[1];
  assign Lth  = flags_reg[0];

endmodule

// File: tb/tb_nbit_seq_comparator.sv
// Directed bench for nbit_seq_comparator (WIDTH=16, CHUNK=4): latency,
// early exit, flag hold, ignored starts, mid-run reset and optional signed mode.
module tb_nbit_seq_comparator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic        Gth;
  logic        E;
  logic        Lth;
`ifdef NBIT_CMP_SIGNED_EN
  logic        is_signed;
`endif

  int checks;
  int errors;
  int lat;
  int busy_cnt;

  nbit_seq_comparator #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef NBIT_CMP_SIGNED_EN
    .is_signed (is_signed),
`endif
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Gth       (Gth),
    .E         (E),
    .Lth       (Lth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges until done is seen at a negedge; bounded so a stuck DUT still ends
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    forever begin
      @(negedge clk);
      if (done || edges >= 40) break;
      if (busy) busy_cycles++;
      tick();
      edges++;
    end
  endtask

  // Issues a one-cycle start; lat counts the accepting edge plus RUN edges
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, busy_cnt);
    lat = lat + 1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
`ifdef NBIT_CMP_SIGNED_EN
    is_signed = 1'b0;
`endif
    tick();
    tick();
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_flags", {29'd0, Gth, E, Lth}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: first-chunk exit
    launch(16'h8000, 16'h7FFF);
    $display("txn1 A=8000 B=7FFF lat=%0d busy=%0d flags=%b%b%b", lat, busy_cnt, Gth, E, Lth);
    check("t1_latency", lat, 32'd2);
    check("t1_busy_cycles", busy_cnt, 32'd1);
    check("t1_flags", {29'd0, Gth, E, Lth}, 32'b100);
    check("t1_busy_in_done", {31'd0, busy}, 32'd0);
    tick();
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_flags_hold", {29'd0, Gth, E, Lth}, 32'b100);
    tick();

    // 2: three equal chunks then less-than
    launch(16'h1234, 16'h1235);
    $display("txn2 A=1234 B=1235 lat=%0d busy=%0d flags=%b%b%b", lat, busy_cnt, Gth, E, Lth);
    check("t2_latency", lat, 32'd5);
    check("t2_busy_cycles", busy_cnt, 32'd4);
    check("t2_flags", {29'd0, Gth, E, Lth}, 32'b001);
    tick();

    // 3: equal operands, start held during DONE, flags held while idle
    launch(16'hBEEF, 16'hBEEF);
    $display("txn3 A=BEEF B=BEEF lat=%0d busy=%0d flags=%b%b%b", lat, busy_cnt, Gth, E, Lth);
    check("t3_latency", lat, 32'd5);
    check("t3_flags", {29'd0, Gth, E, Lth}, 32'b010);
    start = 1'b1;
    A = 16'h0001;
    B = 16'h0000;
    tick();
    @(negedge clk);
    start = 1'b0;
    check("t3_done_start_ignored", {30'd0, busy, done}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("t3_idle_busy", {31'd0, busy}, 32'd0);
    check("t3_idle_flags", {29'd0, Gth, E, Lth}, 32'b010);
    tick();

    // 4: second start during RUN is ignored
    A = 16'h1111;
    B = 16'h1112;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 16'hF000;
    B = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, busy_cnt);
    $display("txn4 A=1111 B=1112 rest=%0d flags=%b%b%b", lat, Gth, E, Lth);
    check("t4_remaining_edges", lat, 32'd1);
    check("t4_flags", {29'd0, Gth, E, Lth}, 32'b001);
    tick();
    tick();
    @(negedge clk);
    check("t4_no_queued_run", {30'd0, busy, done}, 32'd0);
    tick();

    // 5: reset in second RUN cycle, then fresh compare
    A = 16'h1230;
    B = 16'h1200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    $display("txn5 reset mid-run busy=%b done=%b flags=%b%b%b", busy, done, Gth, E, Lth);
    check("t5_reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("t5_reset_flags", {29'd0, Gth, E, Lth}, 32'd0);
    rst_n = 1'b1;
    tick();
    launch(16'h00FF, 16'h00FE);
    $display("txn5b A=00FF B=00FE lat=%0d flags=%b%b%b", lat, Gth, E, Lth);
    check("t5_post_reset_latency", lat, 32'd5);
    check("t5_post_reset_flags", {29'd0, Gth, E, Lth}, 32'b100);
    tick();

    // 6: -1 vs 1 under signed and unsigned interpretation
`ifdef NBIT_CMP_SIGNED_EN
    is_signed = 1'b1;
    launch(16'hFFFF, 16'h0001);
    is_signed = 1'b0;
    $display("txn6s A=FFFF B=0001 signed lat=%0d flags=%b%b%b", lat, Gth, E, Lth);
    check("t6_signed_latency", lat, 32'd2);
    check("t6_signed_flags", {29'd0, Gth, E, Lth}, 32'b001);
    tick();
`endif
    launch(16'hFFFF, 16'h0001);
    $display("txn6u A=FFFF B=0001 unsigned lat=%0d flags=%b%b%b", lat, Gth, E, Lth);
    check("t6_unsigned_latency", lat, 32'd2);
    check("t6_unsigned_flags", {29'd0, Gth, E, Lth}, 32'b100);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
